// File: rtl/duck_motion.sv
// Per-duck motion and animation controller.
// Moves the duck once per video frame (fly / hit pause / fall / escape) and
// maps the pixel being drawn onto the 80x80 sprite atlas (four 40x40 cells)
// for the colour mapper downstream.
module duck_motion #(
    parameter int SPR          = 40,   // sprite cell edge in pixels
    parameter int SCREEN_W     = 640,  // visible width
    parameter int GROUND_Y     = 360,  // spawn / landing top-left Y
    parameter int FLY_SPEED    = 2,    // pixels per frame per axis in flight
    parameter int ESC_SPEED    = 4,    // upward pixels per frame when escaping
    parameter int FALL_SPEED   = 3,    // downward pixels per frame when falling
    parameter int FLY_FRAMES   = 300,  // frames of flight before escape
    parameter int PAUSE_FRAMES = 30,   // frames frozen after a hit
    parameter int ANIM_FRAMES  = 8     // frames between wing-cell toggles
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       spawn,
    input  logic       hit,
    output logic       is_duck,
    output logic [9:0] Duck_Draw_X,
    output logic [9:0] Duck_Draw_Y,
    output logic [2:0] duck_state,
    output logic       duck_down,
    output logic       escaped
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FLY       = 3'd1,
        S_HIT_PAUSE = 3'd2,
        S_FALL      = 3'd3,
        S_ESCAPE    = 3'd4
    } state_t;

    // Signed 11-bit constants so edge tests on the next position never wrap.
    localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - SPR);
    localparam logic signed [10:0] Y_MAX  = 11'(GROUND_Y);
    localparam logic signed [10:0] FLY_S  = 11'(FLY_SPEED);
    localparam logic signed [10:0] FALL_S = 11'(FALL_SPEED);
    localparam logic [9:0] X_MAX_U   = 10'(SCREEN_W - SPR);
    localparam logic [9:0] GROUND_U  = 10'(GROUND_Y);
    localparam logic [9:0] ESC_U     = 10'(ESC_SPEED);
    localparam logic [9:0] SPR_U     = 10'(SPR);
    localparam logic [9:0] SPR_LAST  = 10'(SPR - 1);
    localparam logic [8:0] FLY_LAST  = 9'(FLY_FRAMES - 1);
    localparam logic [8:0] PAUSE_LAST = 9'(PAUSE_FRAMES - 1);
    localparam logic [8:0] ANIM_N    = 9'(ANIM_FRAMES);

    state_t      state, state_n;
    logic [9:0]  pos_x, pos_x_n, pos_y, pos_y_n;
    logic        dir_left, dir_left_n;   // 0 = moving right (+1), 1 = left
    logic        dir_down, dir_down_n;   // 0 = moving up (-1), 1 = down
    logic [8:0]  cnt, cnt_n, cnt_inc;
    logic        wing, wing_n, anim_wrap;
    logic        duck_down_n, escaped_n;
    logic [9:0]  lfsr;
    logic [2:0]  fc_sync;
    logic        frame_tick;

    logic signed [10:0] fly_x, fly_y, fall_y;
    logic [9:0]  lfsr_lo, spawn_x;

    // Frame-clock synchroniser and free-running 10-bit LFSR (taps 10,7).
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_sync <= '0;
            lfsr    <= 10'h2A5;
        end else begin
            fc_sync <= {fc_sync[1:0], frame_clk};
            lfsr    <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

    // Rising edge of the twice-registered frame clock.
    assign frame_tick = fc_sync[1] & ~fc_sync[2];

    // Next-position arithmetic shared by the state machine.
    assign fly_x     = $signed({1'b0, pos_x}) + (dir_left ? -FLY_S : FLY_S);
    assign fly_y     = $signed({1'b0, pos_y}) + (dir_down ? FLY_S : -FLY_S);
    assign fall_y    = $signed({1'b0, pos_y}) + FALL_S;
    assign cnt_inc   = cnt + 9'd1;
    assign anim_wrap = (cnt_inc % ANIM_N) == 9'd0;
    assign lfsr_lo   = {1'b0, lfsr[8:0]};
    assign spawn_x   = (lfsr_lo >= X_MAX_U) ? lfsr_lo - X_MAX_U : lfsr_lo;

    // State and motion registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= S_IDLE;
            pos_x     <= '0;
            pos_y     <= GROUND_U;
            dir_left  <= 1'b0;
            dir_down  <= 1'b0;
            cnt       <= '0;
            wing      <= 1'b0;
            duck_down <= 1'b0;
            escaped   <= 1'b0;
        end else begin
            state     <= state_n;
            pos_x     <= pos_x_n;
            pos_y     <= pos_y_n;
            dir_left  <= dir_left_n;
            dir_down  <= dir_down_n;
            cnt       <= cnt_n;
            wing      <= wing_n;
            duck_down <= duck_down_n;
            escaped   <= escaped_n;
        end
    end

    // Next-state and next-motion logic.
    // NOTE: every signal gets a default first so no path can infer a latch.
    always_comb begin
        state_n     = state;
        pos_x_n     = pos_x;
        pos_y_n     = pos_y;
        dir_left_n  = dir_left;
        dir_down_n  = dir_down;
        cnt_n       = cnt;
        wing_n      = wing;
        duck_down_n = 1'b0;
        escaped_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (spawn) begin
                    pos_x_n    = spawn_x;
                    pos_y_n    = GROUND_U;
                    dir_left_n = lfsr[9];
                    dir_down_n = 1'b0;
                    cnt_n      = '0;
                    wing_n     = 1'b0;
                    state_n    = S_FLY;
                end
            end
            S_FLY: begin
                // A hit wins over a same-cycle frame tick: freeze in place.
                if (hit) begin
                    state_n = S_HIT_PAUSE;
                    cnt_n   = '0;
                end else if (frame_tick) begin
                    // Reaching an edge counts as a bounce.
                    if (fly_x <= 11'sd0) begin
                        pos_x_n    = '0;
                        dir_left_n = 1'b0;
                    end else if (fly_x >= X_MAX) begin
                        pos_x_n    = X_MAX_U;
                        dir_left_n = 1'b1;
                    end else begin
                        pos_x_n = fly_x[9:0];
                    end
                    if (fly_y <= 11'sd0) begin
                        pos_y_n    = '0;
                        dir_down_n = 1'b1;
                    end else if (fly_y >= Y_MAX) begin
                        pos_y_n    = GROUND_U;
                        dir_down_n = 1'b0;
                    end else begin
                        pos_y_n = fly_y[9:0];
                    end
                    cnt_n = cnt_inc;
                    if (anim_wrap) wing_n = ~wing;
                    if (cnt == FLY_LAST) state_n = S_ESCAPE;
                end
            end
            S_HIT_PAUSE: begin
                if (frame_tick) begin
                    if (cnt == PAUSE_LAST) begin
                        state_n = S_FALL;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            S_FALL: begin
                if (frame_tick) begin
                    if (fall_y >= Y_MAX) begin
                        pos_y_n     = GROUND_U;
                        duck_down_n = 1'b1;
                        state_n     = S_IDLE;
                    end else begin
                        pos_y_n = fall_y[9:0];
                    end
                end
            end
            S_ESCAPE: begin
                if (frame_tick) begin
                    if (pos_y <= ESC_U) begin
                        escaped_n = 1'b1;
                        state_n   = S_IDLE;
                    end else begin
                        pos_y_n = pos_y - ESC_U;
                        cnt_n   = cnt_inc;
                        if (anim_wrap) wing_n = ~wing;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Hit-box test and sprite-atlas coordinates for the current pixel.
    logic       in_x, in_y, col, row, flip;
    logic [9:0] lx, ly, lx_m;

    assign in_x = ({1'b0, DrawX} >= {1'b0, pos_x}) &&
                  ({1'b0, DrawX} <= {1'b0, pos_x} + {1'b0, SPR_LAST});
    assign in_y = ({1'b0, DrawY} >= {1'b0, pos_y}) &&
                  ({1'b0, DrawY} <= {1'b0, pos_y} + {1'b0, SPR_LAST});
    assign lx   = DrawX - pos_x;
    assign ly   = DrawY - pos_y;

    // Cell selection: wing cells in flight, pose cells after a hit.
    always_comb begin
        col  = 1'b0;
        row  = 1'b0;
        flip = 1'b0;
        case (state)
            S_FLY, S_ESCAPE: begin
                col  = wing;
                flip = dir_left;
            end
            S_HIT_PAUSE: row = 1'b1;
            S_FALL: begin
                col = 1'b1;
                row = 1'b1;
            end
            default: ;
        endcase
        is_duck     = (state != S_IDLE) && in_x && in_y;
        lx_m        = flip ? (SPR_LAST - lx) : lx;
        Duck_Draw_X = is_duck ? lx_m + (col ? SPR_U : 10'd0) : 10'd0;
        Duck_Draw_Y = is_duck ? ly + (row ? SPR_U : 10'd0) : 10'd0;
    end

    assign duck_state = state;

endmodule

// File: tb/tb_duck_motion.sv
// Directed testbench for duck_motion: spawn, flight bounce, hit/pause/fall,
// escape, ignored requests and asynchronous reset mid-fall.
module tb_duck_motion;

    logic       Clk = 1'b0;
    logic       Reset, frame_clk, spawn, hit;
    logic [9:0] DrawX, DrawY;
    logic       is_duck, duck_down, escaped;
    logic [9:0] Duck_Draw_X, Duck_Draw_Y;
    logic [2:0] duck_state;

    int errors = 0;
    int checks = 0;

    // Reference position model (spec behaviour, plain ints).
    int   mx, my, mcnt;
    bit   mdl, mdd, mwing, mesc;
    logic [9:0] m_lfsr;
    int   dd_cnt = 0;
    int   esc_cnt = 0;

    duck_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY), .spawn(spawn), .hit(hit),
        .is_duck(is_duck), .Duck_Draw_X(Duck_Draw_X), .Duck_Draw_Y(Duck_Draw_Y),
        .duck_state(duck_state), .duck_down(duck_down), .escaped(escaped)
    );

    always #10 Clk = ~Clk;

    // Reference LFSR: reset 10'h2A5, taps 10 and 7, steps every clock.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) m_lfsr <= 10'h2A5;
        else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    // Count pulse cycles, sampled mid-cycle.
    always @(negedge Clk) begin
        if (duck_down === 1'b1) dd_cnt++;
        if (escaped === 1'b1) esc_cnt++;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic probe(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        #1;
    endtask

    // Confirms the hit-box sits exactly at (ex,ey)..(ex+39,ey+39).
    task automatic check_pos(input string tag, input int ex, input int ey);
        probe(ex, ey);           check({tag, "_tl_in"}, is_duck, 1);
        probe(ex + 39, ey + 39); check({tag, "_br_in"}, is_duck, 1);
        probe(ex + 40, ey);      check({tag, "_right_out"}, is_duck, 0);
        probe(ex, ey + 40);      check({tag, "_below_out"}, is_duck, 0);
        if (ex > 0) begin probe(ex - 1, ey); check({tag, "_left_out"}, is_duck, 0); end
        if (ey > 0) begin probe(ex, ey - 1); check({tag, "_above_out"}, is_duck, 0); end
    endtask

    // One frame: frame_clk high for 3 cycles, low for 3; returns on a negedge.
    task automatic frame();
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // One flight frame, with the model advanced per the motion rules.
    task automatic fly_tick();
        int nx, ny;
        frame();
        nx = mx + (mdl ? -2 : 2);
        ny = my + (mdd ? 2 : -2);
        if (nx <= 0) begin mx = 0; mdl = 0; end
        else if (nx >= 600) begin mx = 600; mdl = 1; end
        else mx = nx;
        if (ny <= 0) begin my = 0; mdd = 1; end
        else if (ny >= 360) begin my = 360; mdd = 0; end
        else my = ny;
        if (mcnt == 299) mesc = 1;
        mcnt++;
        if (mcnt % 8 == 0) mwing = ~mwing;
    endtask

    task automatic do_spawn();
        mx = int'(m_lfsr[8:0]);
        if (mx >= 600) mx -= 600;
        my = 360; mdl = m_lfsr[9]; mdd = 0; mcnt = 0; mwing = 0; mesc = 0;
        spawn = 1'b1;
        @(negedge Clk);
        spawn = 1'b0;
    endtask

    initial begin
        int guard, dd0, e0;
        Reset = 1'b1; frame_clk = 1'b0; spawn = 1'b0; hit = 1'b0;
        DrawX = '0; DrawY = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;

        // Reset state
        probe(0, 360);
        check("rst_state", duck_state, 0);
        check("rst_is_duck", is_duck, 0);
        check("rst_draw_x", Duck_Draw_X, 0);
        check("rst_draw_y", Duck_Draw_Y, 0);
        check("rst_duck_down", duck_down, 0);
        check("rst_escaped", escaped, 0);

        // Spawn while the LFSR holds 10'h0C8 -> x=200, moving right
        guard = 0;
        while (m_lfsr !== 10'h0C8 && guard < 2000) begin
            @(negedge Clk);
            guard++;
        end
        if (m_lfsr !== 10'h0C8) begin
            errors++;
            $display("FAIL lfsr_seek: value 0x0C8 not reached");
        end
        do_spawn();
        check("spawn_state", duck_state, 1);
        check_pos("spawn", 200, 360);
        probe(200, 360);
        check("spawn_draw_x_tl", Duck_Draw_X, 0);
        check("spawn_draw_y_tl", Duck_Draw_Y, 0);
        probe(239, 399);
        check("spawn_draw_x_br", Duck_Draw_X, 39);
        check("spawn_draw_y_br", Duck_Draw_Y, 39);

        // First tick: (202,358)
        fly_tick();
        check_pos("tick1", 202, 358);

        // Fly right until x=598, then bounce off the right edge
        guard = 0;
        while (mx != 598 && guard < 300) begin fly_tick(); guard++; end
        check_pos("x598", 598, my);
        probe(598, my);
        check("x598_draw_x", Duck_Draw_X, mwing ? 40 : 0);
        fly_tick();
        check_pos("x600", 600, my);
        probe(600, my);
        check("x600_flip_draw_x", Duck_Draw_X, mwing ? 79 : 39);
        check("x600_draw_y", Duck_Draw_Y, 0);
        fly_tick();
        check_pos("x598_left", 598, my);

        // Hit coincident with a frame tick: freeze, no motion this frame
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check("hit_state", duck_state, 2);
        check_pos("hit_frozen", 598, my);
        probe(598, my);
        check("hit_draw_x", Duck_Draw_X, 0);
        check("hit_draw_y", Duck_Draw_Y, 40);

        // 30 pause frames, then FALL
        repeat (29) frame();
        check("pause29_state", duck_state, 2);
        frame();
        check("pause30_state", duck_state, 3);
        check_pos("fall_start", 598, my);
        probe(598, my);
        check("fall_draw_x", Duck_Draw_X, 40);
        check("fall_draw_y", Duck_Draw_Y, 40);

        // Fall 3 px per frame until landing at 360
        dd0 = dd_cnt;
        guard = 0;
        while (my + 3 < 360 && guard < 200) begin frame(); my += 3; guard++; end
        check("fall_pre_state", duck_state, 3);
        check("fall_pre_no_pulse", dd_cnt - dd0, 0);
        check_pos("fall_pre", 598, my);
        frame();
        check("land_pulse_once", dd_cnt - dd0, 1);
        check("land_state", duck_state, 0);
        probe(598, 360);
        check("land_is_duck_ground", is_duck, 0);
        probe(600, my);
        check("land_is_duck_last", is_duck, 0);
        check("land_draw_x", Duck_Draw_X, 0);
        check("land_draw_y", Duck_Draw_Y, 0);

        // Hit in IDLE is ignored
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        @(negedge Clk);
        check("idle_hit_state", duck_state, 0);

        // Second duck: no hit for 300 frames -> ESCAPE
        do_spawn();
        check("spawn2_state", duck_state, 1);
        check_pos("spawn2", mx, 360);
        repeat (299) fly_tick();
        check("fly299_state", duck_state, 1);
        fly_tick();
        check("fly300_state", duck_state, 4);
        check_pos("esc_start", mx, my);
        probe(mx, my);
        check("esc_draw_x", Duck_Draw_X, (mdl ? 39 : 0) + (mwing ? 40 : 0));
        check("esc_draw_y", Duck_Draw_Y, 0);

        // Spawn during ESCAPE is ignored
        spawn = 1'b1;
        @(negedge Clk);
        spawn = 1'b0;
        @(negedge Clk);
        check("esc_spawn_state", duck_state, 4);
        check_pos("esc_spawn_pos", mx, my);

        // Climb 4 px per frame; escaped pulses once when y <= 4
        e0 = esc_cnt;
        guard = 0;
        while (my > 4 && guard < 200) begin frame(); my -= 4; guard++; end
        check("esc_pre_state", duck_state, 4);
        check("esc_pre_no_pulse", esc_cnt - e0, 0);
        check_pos("esc_pre", mx, my);
        frame();
        check("esc_pulse_once", esc_cnt - e0, 1);
        check("esc_end_state", duck_state, 0);

        // Third duck: asynchronous reset in the middle of a fall
        do_spawn();
        fly_tick();
        fly_tick();
        hit = 1'b1;
        @(negedge Clk);
        hit = 1'b0;
        @(negedge Clk);
        check("hit2_state", duck_state, 2);
        repeat (30) frame();
        frame();
        my += 3;
        check("fall2_state", duck_state, 3);
        probe(mx, my);
        check("fall2_is_duck", is_duck, 1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_state", duck_state, 0);
        check("async_rst_is_duck", is_duck, 0);
        check("async_rst_draw_x", Duck_Draw_X, 0);
        check("async_rst_draw_y", Duck_Draw_Y, 0);
        check("async_rst_duck_down", duck_down, 0);
        check("async_rst_escaped", escaped, 0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("post_rst_state", duck_state, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
